// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
interface if_id_queue_if #(
  parameter int unsigned AW = 2
);
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          if_ready;
  logic          flush;
  logic          id_freeze;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instr;
  logic [AW:0]   count;

  // Environment side: fetch, hazard unit and branch logic.
  modport master (
    output if_valid, if_pc, if_instr, flush, id_freeze,
    input  if_ready, id_valid, id_pc, id_instr, count
  );

  // Queue side.
  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_freeze,
    output if_ready, id_valid, id_pc, id_instr, count
  );
endinterface

// File: rtl/if_id_queue.sv
// First-word fall-through queue between fetch and decode; flush empties it.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave bus
);

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          enq, deq;
  logic          id_valid;
  logic [63:0]   head;

  assign bus.if_ready = (count_q != Full);
  assign id_valid     = (count_q != '0);
  assign bus.id_valid = id_valid;
  assign bus.count    = count_q;

  // Head is read straight from storage; no bypass from the fetch side.
  assign head         = mem[rd_ptr_q];
  assign bus.id_pc    = id_valid ? head[63:32] : 32'h0;
  assign bus.id_instr = id_valid ? head[31:0]  : 32'h0;

  // Handshakes and next pointer/occupancy; flush overrides both directions.
  always_comb begin
    enq      = bus.if_valid & bus.if_ready;
    deq      = id_valid & ~bus.id_freeze;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW + 1)'(enq) - (AW + 1)'(deq);
    end
  end

  // Pointer and occupancy registers; reset discards contents at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq && !bus.flush) mem[wr_ptr_q] <= {bus.if_pc, bus.if_instr};
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({bus.if_valid, bus.flush, bus.id_freeze}));
  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= Full);
  a_ready_full: assert property (@(posedge clk) disable iff (rst)
    bus.if_ready == (count_q != Full));
  a_valid_empty: assert property (@(posedge clk) disable iff (rst)
    bus.id_valid == (count_q != '0));

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling queue between the instruction-fetch stage and the decode stage.
- Buffers up to DEPTH fetched (PC, instruction) pairs so a decode-side stall does not immediately stall fetch.
- Drops all buffered entries when a branch is taken.
- Its if_ready output drives the fetch stage's freeze input (freeze = ~if_ready); its head entry feeds decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch presents a valid pair this cycle.
- if_pc  input  32  PC+4 value produced by fetch for the instruction.
- if_instr  input  32  fetched instruction word.
- if_ready  output  1  queue can accept; equals (count < DEPTH).
- flush  input  1  branch taken; discards all contents.
- id_freeze  input  1  decode stall from hazard unit; blocks dequeue.
- id_valid  output  1  head entry valid; equals (count != 0).
- id_pc  output  32  head PC+4; 0 when id_valid=0.
- id_instr  output  32  head instruction; 0 when id_valid=0.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: id_valid=0, id_pc=0, id_instr=0, if_ready=1.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Enqueue: enq = if_valid & if_ready. On the edge, write {if_pc, if_instr} at wr_ptr, then wr_ptr += 1 (mod DEPTH).
- Dequeue: deq = id_valid & ~id_freeze. On the edge, rd_ptr += 1 (mod DEPTH). Decode samples id_pc/id_instr in the same cycle that deq is true.
- First-word fall-through:
  - id_pc/id_instr are read combinationally from storage[rd_ptr], gated by id_valid.
  - A pair enqueued into an empty queue appears at the outputs in the cycle after the write edge. Minimum latency is 1 cycle; there is no combinational bypass from if_* to id_*.
- Occupancy update: count_next = count + enq - deq.
  - Simultaneous enq and deq with 0 < count < DEPTH leaves count unchanged.
- Full (count=DEPTH):
  - if_ready=0, so enqueue is blocked even if a dequeue occurs in the same cycle; no pass-through when full.
  - if_ready returns to 1 in the cycle after the dequeue.
- Empty (count=0): id_valid=0 and deq is impossible; id_freeze is ignored.
- Flush (synchronous):
  - On the edge where flush=1: wr_ptr=0, rd_ptr=0, count=0.
  - Any enq or deq requested in that cycle is discarded (flush has priority over both).
  - In the flush cycle itself, outputs still show the pre-flush head; decode is responsible for squashing it.
  - From the next cycle: id_valid=0, if_ready=1.
- Flush and id_freeze together: flush wins; the queue empties.
- Pointer wrap-around: pointers wrap modulo DEPTH; full/empty are distinguished solely by count.
- Invariants (assertions):
  - count never exceeds DEPTH and never underflows.
  - if_ready == (count != DEPTH).
  - id_valid == (count != 0).
- Control-input X-handling:
  - Control inputs are treated as 0 only while rst=1.
  - X on if_valid, flush or id_freeze outside reset is an assertion failure.

Test Plan:
- Reset then basic flow: hold rst 2 cycles, then enqueue (0x4, 0xE3A01005) with id_freeze=0 -> id_valid=1 one cycle later with id_pc=0x4, id_instr=0xE3A01005; count returns to 0 after the dequeue edge.
- Fill to full: id_freeze=1, enqueue PCs 0x4, 0x8, 0xC, 0x10, 0x14 on consecutive cycles -> count=4, if_ready=0 after the 4th edge; the 5th pair is not written; release id_freeze -> outputs 0x4, 0x8, 0xC, 0x10 in order, and if_ready=1 one cycle after the first dequeue.
- Concurrent enq/deq at count=2 for 10 cycles -> count stays 2; output order matches input order across pointer wrap (ptr 3 -> 0).
- Flush at count=3 with if_valid=1 and deq active in the same cycle -> next cycle count=0, id_valid=0, id_pc=0; the concurrently offered pair is absent; a subsequent enqueue of PC 0x100 is the next output.
- Async reset mid-stream: assert rst between clock edges at count=3 -> count=0, id_valid=0, if_ready=1 immediately, without waiting for clk.
- Flush with id_freeze=1 at full -> queue empties, if_ready=1 next cycle.
